// File: rtl/fct_credit_sched_if.sv
// Handshake and status bundle between the RX FIFO, the FCT scheduler and the TX encoder.
interface fct_credit_sched_if #(
    parameter int AWIDTH = 6
) ();
    logic              link_enable;
    logic [AWIDTH-1:0] fifo_count;
    logic              nchar_rx;
    logic              fct_req;
    logic              fct_ack;
    logic [AWIDTH-1:0] credit_outstanding;
    logic              credit_error;
    logic              fct_pending;

    modport master (
        output link_enable, fifo_count, nchar_rx, fct_ack,
        input  fct_req, credit_outstanding, credit_error, fct_pending
    );

    modport slave (
        input  link_enable, fifo_count, nchar_rx, fct_ack,
        output fct_req, credit_outstanding, credit_error, fct_pending
    );
endinterface

// File: rtl/fct_credit_sched.sv
// SpaceWire receive flow-control scheduler: tracks credit held by the far end
// and requests one FCT at a time from the encoder when FIFO space allows.
module fct_credit_sched #(
    parameter int AWIDTH      = 6,
    parameter int MAX_FILL    = 56,
    parameter int CREDIT_STEP = 8,
    parameter int MAX_CREDIT  = 56,
    parameter int HOLDOFF     = 4
) (
    input  logic                clock,
    input  logic                reset,
    fct_credit_sched_if.slave   bus
);
    localparam int HW      = $clog2(HOLDOFF + 1);
    localparam int CEIL_I  = MAX_CREDIT - CREDIT_STEP;
    localparam int ONE_I   = 1;
    localparam int ZERO_I  = 0;

    localparam logic [AWIDTH:0]   FILL_W  = MAX_FILL[AWIDTH:0];
    localparam logic [AWIDTH:0]   STEP_W  = CREDIT_STEP[AWIDTH:0];
    localparam logic [AWIDTH:0]   CEIL_W  = CEIL_I[AWIDTH:0];
    localparam logic [AWIDTH:0]   ZERO_W  = ZERO_I[AWIDTH:0];
    localparam logic [AWIDTH-1:0] STEP_A  = CREDIT_STEP[AWIDTH-1:0];
    localparam logic [AWIDTH-1:0] ONE_A   = ONE_I[AWIDTH-1:0];
    localparam logic [AWIDTH-1:0] ZERO_A  = ZERO_I[AWIDTH-1:0];
    localparam logic [HW-1:0]     LOAD_H  = HOLDOFF[HW-1:0];
    localparam logic [HW-1:0]     ONE_H   = ONE_I[HW-1:0];
    localparam logic [HW-1:0]     ZERO_H  = ZERO_I[HW-1:0];

    localparam logic [1:0] ST_DISABLED = 2'd0;
    localparam logic [1:0] ST_IDLE     = 2'd1;
    localparam logic [1:0] ST_REQUEST  = 2'd2;
    localparam logic [1:0] ST_HOLDOFF  = 2'd3;

    logic [1:0]        state_q, state_d;
    logic [HW-1:0]     hold_cnt_q, hold_cnt_d;
    logic              fct_req_q, fct_req_d;
    logic [AWIDTH-1:0] credit_q, credit_d;
    logic              credit_error_q, credit_error_d;
    logic              fct_pending_q, fct_pending_d;

    logic [AWIDTH:0]   fifo_w_s;
    logic [AWIDTH:0]   credit_w_s;
    logic [AWIDTH:0]   free_s;
    logic              grant_ok_s;
    logic              ack_s;
    logic              consume_s;
    logic              underflow_s;

    // An ack only counts while our request is actually visible to the encoder.
    assign ack_s       = (state_q == ST_REQUEST) && fct_req_q && bus.fct_ack;
    assign consume_s   = bus.nchar_rx && (credit_q != ZERO_A);
    assign underflow_s = bus.nchar_rx && (credit_q == ZERO_A);

    // Free space and grant decision, one bit wider so the sum never wraps.
    always_comb begin
        fifo_w_s   = {1'b0, bus.fifo_count};
        credit_w_s = {1'b0, credit_q};
        if (fifo_w_s > FILL_W) begin
            free_s = ZERO_W;
        end else begin
            free_s = FILL_W - fifo_w_s;
        end
        grant_ok_s = (free_s >= (credit_w_s + STEP_W)) && (credit_w_s <= CEIL_W);
    end

    // Scheduler state, holdoff timer and registered request.
    always_comb begin
        state_d    = state_q;
        hold_cnt_d = hold_cnt_q;
        fct_req_d  = 1'b0;
        if (!bus.link_enable) begin
            state_d    = ST_DISABLED;
            hold_cnt_d = ZERO_H;
        end else begin
            case (state_q)
                ST_DISABLED: begin
                    state_d    = ST_IDLE;
                    hold_cnt_d = ZERO_H;
                end
                ST_IDLE: begin
                    if (grant_ok_s) begin
                        state_d = ST_REQUEST;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_REQUEST: begin
                    if (ack_s) begin
                        state_d    = ST_HOLDOFF;
                        hold_cnt_d = LOAD_H;
                    end else begin
                        fct_req_d  = 1'b1;
                    end
                end
                ST_HOLDOFF: begin
                    if (hold_cnt_q <= ONE_H) begin
                        state_d    = ST_IDLE;
                        hold_cnt_d = ZERO_H;
                    end else begin
                        hold_cnt_d = hold_cnt_q - ONE_H;
                    end
                end
                default: begin
                    state_d    = ST_DISABLED;
                    hold_cnt_d = ZERO_H;
                end
            endcase
        end
        fct_pending_d = (state_d == ST_REQUEST) || (state_d == ST_HOLDOFF);
    end

    // Credit bookkeeping; an underflowing N-char latches the error instead of wrapping.
    always_comb begin
        credit_d       = credit_q;
        credit_error_d = credit_error_q;
        if (!bus.link_enable || (state_q == ST_DISABLED)) begin
            credit_d       = ZERO_A;
            credit_error_d = 1'b0;
        end else begin
            credit_d = credit_q + (ack_s ? STEP_A : ZERO_A) - (consume_s ? ONE_A : ZERO_A);
            if (underflow_s) begin
                credit_error_d = 1'b1;
            end else begin
                credit_error_d = credit_error_q;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= ST_DISABLED;
            hold_cnt_q     <= ZERO_H;
            fct_req_q      <= 1'b0;
            credit_q       <= ZERO_A;
            credit_error_q <= 1'b0;
            fct_pending_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            hold_cnt_q     <= hold_cnt_d;
            fct_req_q      <= fct_req_d;
            credit_q       <= credit_d;
            credit_error_q <= credit_error_d;
            fct_pending_q  <= fct_pending_d;
        end
    end

    assign bus.fct_req            = fct_req_q;
    assign bus.credit_outstanding = credit_q;
    assign bus.credit_error       = credit_error_q;
    assign bus.fct_pending        = fct_pending_q;
endmodule

// File: tb/tb_fct_credit_sched.sv
// Randomised and directed bench for fct_credit_sched against a cycle-level behavioural model.
module tb_fct_credit_sched;
    localparam int AWIDTH      = 6;
    localparam int MAX_FILL    = 56;
    localparam int CREDIT_STEP = 8;
    localparam int MAX_CREDIT  = 56;
    localparam int HOLDOFF     = 4;

    localparam int P_OFF  = 0;
    localparam int P_IDLE = 1;
    localparam int P_REQ  = 2;
    localparam int P_HOLD = 3;

    logic clock = 1'b0;
    logic reset = 1'b0;

    fct_credit_sched_if #(.AWIDTH(AWIDTH)) bus ();

    fct_credit_sched #(
        .AWIDTH(AWIDTH), .MAX_FILL(MAX_FILL), .CREDIT_STEP(CREDIT_STEP),
        .MAX_CREDIT(MAX_CREDIT), .HOLDOFF(HOLDOFF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_bad = 0;

    // behavioural model state
    int phase    = P_OFF;
    int m_credit = 0;
    int m_err    = 0;
    int m_req    = 0;
    int m_wait   = 0;
    int m_fcts   = 0;

    // ack responder
    bit auto_ack = 1'b0;
    bit lat_rand = 1'b0;
    bit spurious = 1'b0;
    int ack_lat  = 1;
    int req_age  = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        int free;
        int nc;
        bit acc;
        if (!reset) begin
            phase = P_OFF; m_credit = 0; m_err = 0; m_req = 0; m_wait = 0;
        end else if (!bus.link_enable) begin
            phase = P_OFF; m_credit = 0; m_err = 0; m_req = 0; m_wait = 0;
        end else if (phase == P_OFF) begin
            phase = P_IDLE; m_credit = 0; m_err = 0; m_req = 0;
        end else begin
            free = (int'(bus.fifo_count) > MAX_FILL) ? 0 : MAX_FILL - int'(bus.fifo_count);
            acc  = (phase == P_REQ) && (m_req == 1) && bus.fct_ack;
            nc   = m_credit;
            if (bus.nchar_rx) begin
                if (m_credit > 0) nc = nc - 1;
                else m_err = 1;
            end
            if (acc) begin
                nc = nc + CREDIT_STEP;
                m_fcts++;
            end
            m_req = 0;
            case (phase)
                P_IDLE:
                    if (free >= m_credit + CREDIT_STEP && m_credit <= MAX_CREDIT - CREDIT_STEP)
                        phase = P_REQ;
                P_REQ:
                    if (acc) begin
                        phase = P_HOLD; m_wait = HOLDOFF;
                    end else begin
                        m_req = 1;
                    end
                P_HOLD: begin
                    m_wait = m_wait - 1;
                    if (m_wait == 0) phase = P_IDLE;
                end
                default: phase = P_OFF;
            endcase
            m_credit = nc;
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        model_edge();
        @(negedge clock);
        chk("fct_req", int'(bus.fct_req), m_req);
        chk("credit_outstanding", int'(bus.credit_outstanding), m_credit);
        chk("credit_error", int'(bus.credit_error), m_err);
        chk("fct_pending", int'(bus.fct_pending), int'(phase == P_REQ || phase == P_HOLD));
        if (auto_ack) begin
            if (m_req == 1) begin
                if (req_age == 0 && lat_rand) ack_lat = $urandom_range(0, 5);
                bus.fct_ack = (req_age >= ack_lat);
                req_age++;
            end else begin
                req_age = 0;
                bus.fct_ack = spurious ? ($urandom_range(0, 3) == 0) : 1'b0;
            end
        end
    endtask

    task automatic wait_req(input string name, input int budget);
        int k;
        k = 0;
        while (m_req == 0 && k < budget) begin
            cyc();
            k++;
        end
        n_vec++;
        if (m_req == 0) begin
            n_bad++;
            $display("FAIL %s: no request within %0d cycles, got fct_req=%0d expected 1", name, budget, bus.fct_req);
        end
    endtask

    task automatic pulse_nchar(input int n);
        for (int i = 0; i < n; i++) begin
            bus.nchar_rx = 1'b1;
            cyc();
        end
        bus.nchar_rx = 1'b0;
    endtask

    initial begin
        int fcts_before;
        bus.link_enable = 1'b0;
        bus.fifo_count  = '0;
        bus.nchar_rx    = 1'b0;
        bus.fct_ack     = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst_fct_req", int'(bus.fct_req), 0);
        chk("rst_credit", int'(bus.credit_outstanding), 0);
        chk("rst_error", int'(bus.credit_error), 0);
        chk("rst_pending", int'(bus.fct_pending), 0);
        reset = 1'b1;

        // seven FCTs fill the far end to MAX_CREDIT with an empty FIFO
        bus.link_enable = 1'b1;
        auto_ack = 1'b1; ack_lat = 1;
        repeat (150) cyc();
        chk("fill_credit", int'(bus.credit_outstanding), 56);
        chk("fill_fct_count", m_fcts, 7);
        chk("fill_req_low", int'(bus.fct_req), 0);

        // FIFO holding 8 blocks a new grant until it drains
        bus.fifo_count = 6'd8;
        pulse_nchar(8);
        repeat (20) cyc();
        chk("blocked_credit", int'(bus.credit_outstanding), 48);
        chk("blocked_fct_count", m_fcts, 7);
        bus.fifo_count = 6'd0;
        repeat (30) cyc();
        chk("drain_credit", int'(bus.credit_outstanding), 56);
        chk("drain_fct_count", m_fcts, 8);

        // encoder stalls the ack for 10 cycles
        auto_ack = 1'b0; bus.fct_ack = 1'b0;
        bus.fifo_count = 6'd8;
        pulse_nchar(8);
        bus.fifo_count = 6'd0;
        wait_req("stall_req", 20);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("stall_req_held", int'(bus.fct_req), 1);
            chk("stall_credit_held", int'(bus.credit_outstanding), 48);
        end
        bus.fct_ack = 1'b1;
        cyc();
        bus.fct_ack = 1'b0;
        chk("stall_ack_credit", int'(bus.credit_outstanding), 56);
        chk("stall_ack_req", int'(bus.fct_req), 0);

        // ack and N-char in the same cycle at credit 8
        bus.link_enable = 1'b0;
        cyc(); cyc();
        bus.link_enable = 1'b1;
        bus.fifo_count = 6'd40;
        wait_req("coinc_req1", 20);
        bus.fct_ack = 1'b1; cyc(); bus.fct_ack = 1'b0;
        chk("coinc_credit8", int'(bus.credit_outstanding), 8);
        wait_req("coinc_req2", 30);
        bus.fct_ack = 1'b1; bus.nchar_rx = 1'b1;
        cyc();
        bus.fct_ack = 1'b0; bus.nchar_rx = 1'b0;
        chk("coinc_credit15", int'(bus.credit_outstanding), 15);

        // N-char with zero credit, then link drop clears the error
        bus.link_enable = 1'b0; cyc();
        bus.link_enable = 1'b1; bus.fifo_count = 6'd56;
        cyc(); cyc();
        pulse_nchar(1);
        chk("underflow_error", int'(bus.credit_error), 1);
        chk("underflow_credit", int'(bus.credit_outstanding), 0);
        bus.link_enable = 1'b0; cyc();
        chk("error_cleared", int'(bus.credit_error), 0);

        // link drops in the very cycle the encoder acks at credit 24
        bus.link_enable = 1'b1; bus.fifo_count = 6'd24;
        for (int i = 0; i < 3; i++) begin
            wait_req("drop_req", 30);
            bus.fct_ack = 1'b1; cyc(); bus.fct_ack = 1'b0;
        end
        wait_req("drop_req4", 30);
        chk("drop_pre_credit", int'(bus.credit_outstanding), 24);
        fcts_before = m_fcts;
        bus.link_enable = 1'b0; bus.fct_ack = 1'b1;
        cyc();
        bus.fct_ack = 1'b0;
        chk("drop_req", int'(bus.fct_req), 0);
        chk("drop_credit", int'(bus.credit_outstanding), 0);
        chk("drop_pending", int'(bus.fct_pending), 0);
        chk("drop_no_grant", m_fcts, fcts_before);

        // randomised traffic with random ack latency and stray acks
        bus.link_enable = 1'b1;
        auto_ack = 1'b1; lat_rand = 1'b1; spurious = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 299) == 0) bus.link_enable = 1'b0;
            else if (!bus.link_enable && $urandom_range(0, 2) == 0) bus.link_enable = 1'b1;
            if ($urandom_range(0, 7) == 0) bus.fifo_count = 6'($urandom_range(0, 63));
            bus.nchar_rx = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
